// File: rtl/dcache_controller.sv
// Direct-mapped write-back write-allocate data cache for the MEM stage.
// Misses stall the pipeline while the victim is flushed and the line refilled.
module dcache_controller #(
  parameter int ADDR_W     = 32,
  parameter int NUM_LINES  = 16,
  parameter int LINE_BYTES = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cpu_req_i,
  input  logic                    cpu_we_i,
  input  logic [ADDR_W-1:0]       cpu_addr_i,
  input  logic [31:0]             cpu_data_i,
  output logic [31:0]             cpu_data_o,
  output logic                    cpu_stall_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [ADDR_W-1:0]       mem_addr_o,
  output logic [8*LINE_BYTES-1:0] mem_data_o,
  input  logic [8*LINE_BYTES-1:0] mem_data_i,
  input  logic                    mem_ack_i
);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int LINE_W = 8 * LINE_BYTES;
  localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
  localparam int WRD_W  = OFF_W - 2;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    REFILL
  } state_t;

  state_t state, state_nx;

  logic [NUM_LINES-1:0] valid, dirty;
  logic [TAG_W-1:0]     tag_arr  [NUM_LINES];
  logic [LINE_W-1:0]    data_arr [NUM_LINES];

  logic [TAG_W-1:0]  req_tag, vic_tag;
  logic [IDX_W-1:0]  lat_idx;
  logic [LINE_W-1:0] vic_line;

  logic [WRD_W-1:0] word;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             hit, miss, store_hit;
  logic             unused_ok;

  assign word = cpu_addr_i[OFF_W-1:2];
  assign idx  = cpu_addr_i[OFF_W+IDX_W-1:OFF_W];
  assign tag  = cpu_addr_i[ADDR_W-1:OFF_W+IDX_W];
  assign unused_ok = ^cpu_addr_i[1:0];

  assign hit       = cpu_req_i & valid[idx] & (tag_arr[idx] == tag);
  assign miss      = cpu_req_i & ~hit & (state == IDLE);
  assign store_hit = hit & cpu_we_i & (state == IDLE);

  assign cpu_stall_o = cpu_req_i & (~hit | (state != IDLE));
  assign cpu_data_o  = (hit & ~cpu_we_i) ?
                       data_arr[idx][{word, 5'b0} +: 32] : '0;

  always_comb begin
    state_nx   = state;
    mem_req_o  = 1'b0;
    mem_we_o   = 1'b0;
    mem_addr_o = '0;
    mem_data_o = '0;
    unique case (state)
      IDLE: begin
        if (miss)
          state_nx = (valid[idx] & dirty[idx]) ? WRITEBACK : REFILL;
      end
      WRITEBACK: begin
        mem_req_o  = 1'b1;
        mem_we_o   = 1'b1;
        mem_addr_o = {vic_tag, lat_idx, {OFF_W{1'b0}}};
        mem_data_o = vic_line;
        if (mem_ack_i) state_nx = REFILL;
      end
      REFILL: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {req_tag, lat_idx, {OFF_W{1'b0}}};
        if (mem_ack_i) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      valid <= '0;
      dirty <= '0;
    end else begin
      state <= state_nx;
      if (state == WRITEBACK && mem_ack_i)
        dirty[lat_idx] <= 1'b0;
      if (state == REFILL && mem_ack_i) begin
        valid[lat_idx] <= 1'b1;
        dirty[lat_idx] <= 1'b0;
      end
      if (store_hit)
        dirty[idx] <= 1'b1;
    end
  end

  // Memory side only ever sees these captured values, never the live CPU address.
  always_ff @(posedge clk_i) begin
    if (!rst_i && miss) begin
      req_tag  <= tag;
      vic_tag  <= tag_arr[idx];
      lat_idx  <= idx;
      vic_line <= data_arr[idx];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state == REFILL && mem_ack_i) begin
        data_arr[lat_idx] <= mem_data_i;
        tag_arr[lat_idx]  <= req_tag;
      end else if (store_hit) begin
        data_arr[idx][{word, 5'b0} +: 32] <= cpu_data_i;
      end
    end
  end

endmodule
